jtframe_bank_arb: RTL and testbench

- Parametrised N-channel requester arbiter for one SDRAM bank port (ba_addr/ba_rd/ba_wr/ba_ack/ba_rdy family).
- Generalises the fixed single-requester-per-bank hookup used by the game/frame connection.
- Arbitrates CH game-side read/write clients with selectable round-robin or fixed priority.
- Sits between game logic and jtframe SDRAM bank inputs, one instance per bank. Returns read data on a shared bus with per-channel completion strobes.

---
 rtl/jtframe_bank_arb.sv | 209 ++++++++++++++++++++
 tb/tb_jtframe_bank_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_bank_arb.sv
// ---------------------------------------------------------------------------
// jtframe_bank_arb
//
// Arbitrates CH game-side read/write clients onto a single jtframe SDRAM bank
// port. One transaction is in flight at a time. The sequence is:
//   IDLE -> REQ (hold ba_rd/ba_wr until ba_ack)
//        -> WAIT (until ba_rdy)
//        -> DONE (one bubble so the client can drop its request)
// If ba_ack and ba_rdy arrive together, the transaction goes from REQ to DONE.
// With one-cycle ack/rdy latency a transaction takes four cycles.
//
// Ports
//   clk, rst_n      : system clock (clk_rom domain), async active-low reset
//   downloading     : ROM download in progress; blocks new grants when
//                     BLOCK_DL=1
//   ch_rd / ch_wr   : per-channel requests, held until ch_ok.
//                     Write wins if both are set.
//   ch_addr/ch_din/ch_din_m : packed per-channel address, data and byte
//                     masks (active low)
//   ch_ok           : one-cycle completion strobe for the granted channel
//   ch_dout         : last read data, valid with ch_ok, not touched by writes
//   ba_*            : bank request side towards the SDRAM controller
//   sdram_dout      : controller read data, valid with ba_rdy
//   busy            : a transaction is being requested or awaited
// ---------------------------------------------------------------------------
module jtframe_bank_arb #(
  parameter int CH         = 4,
  parameter int AW         = 22,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0,
  parameter int BLOCK_DL   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [CH-1:0]   ch_rd,
  input  logic [CH-1:0]   ch_wr,
  input  logic [CH*AW-1:0] ch_addr,
  input  logic [CH*DW-1:0] ch_din,
  input  logic [CH*2-1:0] ch_din_m,
  output logic [CH-1:0]   ch_ok,
  output logic [DW-1:0]   ch_dout,
  output logic [AW-1:0]   ba_addr,
  output logic            ba_rd,
  output logic            ba_wr,
  output logic [DW-1:0]   ba_din,
  output logic [1:0]      ba_din_m,
  input  logic            ba_ack,
  input  logic            ba_rdy,
  input  logic [DW-1:0]   sdram_dout,
  output logic            busy
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          state_q,    state_d;
  logic [IW-1:0]   gnt_q,      gnt_d;
  logic [IW-1:0]   rr_q,       rr_d;
  logic            is_wr_q,    is_wr_d;
  logic [AW-1:0]   ba_addr_q,  ba_addr_d;
  logic            ba_rd_q,    ba_rd_d;
  logic            ba_wr_q,    ba_wr_d;
  logic [DW-1:0]   ba_din_q,   ba_din_d;
  logic [1:0]      ba_din_m_q, ba_din_m_d;
  logic [CH-1:0]   ch_ok_q,    ch_ok_d;
  logic [DW-1:0]   ch_dout_q,  ch_dout_d;
  logic            busy_q,     busy_d;

  logic [CH-1:0]   pending;
  logic [IW-1:0]   win_idx;
  logic            can_grant;
  int              rr_idx;

  assign pending   = ch_rd | ch_wr;
  assign can_grant = (|pending) && !((BLOCK_DL != 0) && downloading);

  // Winner selection. Each loop walks from the lowest-priority candidate
  // towards the highest, so the last match found is the winner.
  // Round-robin starts one past the previous grant and wraps at CH-1 -> 0,
  // so an index >= CH is never produced, even when CH is not a power of two.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a path
    // that leaves it unassigned would infer a latch.
    win_idx = '0;
    rr_idx  = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = CH - 1; i >= 0; i--) begin
        if (pending[IW'(i)]) win_idx = IW'(i);
      end
    end else begin
      for (int k = CH; k >= 1; k--) begin
        rr_idx = int'(rr_q) + k;
        if (rr_idx >= CH) rr_idx = rr_idx - CH;
        if (pending[IW'(rr_idx)]) win_idx = IW'(rr_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    is_wr_d    = is_wr_q;
    ba_addr_d  = ba_addr_q;
    ba_rd_d    = ba_rd_q;
    ba_wr_d    = ba_wr_q;
    ba_din_d   = ba_din_q;
    ba_din_m_d = ba_din_m_q;
    ch_dout_d  = ch_dout_q;
    busy_d     = busy_q;
    ch_ok_d    = '0;  // strobe: high only in the cycle a completion is registered

    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          gnt_d      = win_idx;
          rr_d       = win_idx;
          is_wr_d    = ch_wr[win_idx];
          ba_addr_d  = ch_addr[int'(win_idx)*AW +: AW];
          ba_din_d   = ch_din[int'(win_idx)*DW +: DW];
          ba_din_m_d = ch_din_m[int'(win_idx)*2 +: 2];
          ba_wr_d    = ch_wr[win_idx];
          ba_rd_d    = !ch_wr[win_idx];
          busy_d     = 1'b1;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          state_d = ST_WAIT;
          // Ack and rdy together: treat it as ack followed by rdy.
          if (ba_rdy) begin
            ch_ok_d[gnt_q] = 1'b1;
            if (!is_wr_q) ch_dout_d = sdram_dout;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        if (ba_rdy) begin
          ch_ok_d[gnt_q] = 1'b1;
          if (!is_wr_q) ch_dout_d = sdram_dout;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, whatever order the simulator runs the blocks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      is_wr_q    <= 1'b0;
      ba_addr_q  <= '0;
      ba_rd_q    <= 1'b0;
      ba_wr_q    <= 1'b0;
      ba_din_q   <= '0;
      ba_din_m_q <= 2'b11;
      ch_ok_q    <= '0;
      ch_dout_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      is_wr_q    <= is_wr_d;
      ba_addr_q  <= ba_addr_d;
      ba_rd_q    <= ba_rd_d;
      ba_wr_q    <= ba_wr_d;
      ba_din_q   <= ba_din_d;
      ba_din_m_q <= ba_din_m_d;
      ch_ok_q    <= ch_ok_d;
      ch_dout_q  <= ch_dout_d;
      busy_q     <= busy_d;
    end
  end

  assign ba_addr  = ba_addr_q;
  assign ba_rd    = ba_rd_q;
  assign ba_wr    = ba_wr_q;
  assign ba_din   = ba_din_q;
  assign ba_din_m = ba_din_m_q;
  assign ch_ok    = ch_ok_q;
  assign ch_dout  = ch_dout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// ---------------------------------------------------------------------------
// tb_jtframe_bank_arb
//
// Directed bench for jtframe_bank_arb. There are two instances:
//   u_dut : round-robin. A manual or automatic ack/rdy responder drives it.
//   u_fp  : fixed priority. An automatic responder always drives it.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_jtframe_bank_arb;

  localparam int CH = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  logic            clk;
  logic            rst_n;
  logic            downloading;
  logic [DW-1:0]   sdram_dout;

  // Round-robin instance signals
  logic [CH-1:0]    ch_rd, ch_wr;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*DW-1:0] ch_din;
  logic [CH*2-1:0]  ch_din_m;
  logic [CH-1:0]    ch_ok;
  logic [DW-1:0]    ch_dout;
  logic [AW-1:0]    ba_addr;
  logic             ba_rd, ba_wr, ba_ack, ba_rdy, busy;
  logic [DW-1:0]    ba_din;
  logic [1:0]       ba_din_m;
  logic             man_ack, man_rdy, rsp_ack, rsp_rdy, auto_rsp;

  // Fixed-priority instance signals
  logic [CH-1:0]    fp_rd;
  logic [CH-1:0]    fp_ok;
  logic [DW-1:0]    fp_dout;
  logic [AW-1:0]    fp_addr;
  logic             fp_ba_rd, fp_ba_wr, fp_ack, fp_rdy, fp_busy;
  logic [DW-1:0]    fp_din;
  logic [1:0]       fp_din_m;

  int n_checks = 0;
  int n_fail   = 0;

  assign ba_ack = auto_rsp ? rsp_ack : man_ack;
  assign ba_rdy = auto_rsp ? rsp_rdy : man_rdy;

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .FIXED_PRIO(0), .BLOCK_DL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_din_m(ch_din_m), .ch_ok(ch_ok), .ch_dout(ch_dout),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
    .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .sdram_dout(sdram_dout), .busy(busy)
  );

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .FIXED_PRIO(1), .BLOCK_DL(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ch_rd(fp_rd), .ch_wr('0), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_din_m(ch_din_m), .ch_ok(fp_ok), .ch_dout(fp_dout),
    .ba_addr(fp_addr), .ba_rd(fp_ba_rd), .ba_wr(fp_ba_wr), .ba_din(fp_din),
    .ba_din_m(fp_din_m), .ba_ack(fp_ack), .ba_rdy(fp_rdy),
    .sdram_dout(sdram_dout), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Automatic controller models: ack one cycle after the request appears,
  // rdy one cycle after the ack has been taken.
  initial begin
    rsp_ack = 1'b0; rsp_rdy = 1'b0;
    fp_ack  = 1'b0; fp_rdy  = 1'b0;
  end

  always @(negedge clk) begin
    rsp_rdy = rsp_ack && !(ba_rd || ba_wr);
    rsp_ack = ba_rd || ba_wr;
    fp_rdy  = fp_ack && !(fp_ba_rd || fp_ba_wr);
    fp_ack  = fp_ba_rd || fp_ba_wr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Wait up to 50 cycles for a completion strobe. On timeout ok stays 0,
  // so the caller's comparison fails.
  task automatic wait_ok(input bit use_fp, output logic [CH-1:0] ok);
    ok = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      ok = use_fp ? fp_ok : ch_ok;
      if (ok != '0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH-1:0] ok;

    rst_n = 1'b0; downloading = 1'b0; sdram_dout = '0;
    ch_rd = '0; ch_wr = '0; ch_addr = '0; ch_din = '0; ch_din_m = '1;
    man_ack = 1'b0; man_rdy = 1'b0; auto_rsp = 1'b0; fp_rd = '0;

    // ---------------- reset values ----------------
    tick();
    check("rst_ba_rd",    64'(ba_rd),    64'h0);
    check("rst_ba_wr",    64'(ba_wr),    64'h0);
    check("rst_ba_addr",  64'(ba_addr),  64'h0);
    check("rst_ba_din_m", 64'(ba_din_m), 64'h3);
    check("rst_busy",     64'(busy),     64'h0);
    check("rst_ch_ok",    64'(ch_ok),    64'h0);
    check("rst_ch_dout",  64'(ch_dout),  64'h0);
    tick();
    rst_n = 1'b1;

    // ---------------- single read on channel 2 ----------------
    ch_addr[2*AW +: AW] = 22'h12345;
    ch_rd = 4'b0100;
    tick();
    check("rd_ba_rd",   64'(ba_rd),   64'h1);
    check("rd_ba_wr",   64'(ba_wr),   64'h0);
    check("rd_ba_addr", 64'(ba_addr), 64'h12345);
    check("rd_busy",    64'(busy),    64'h1);
    tick();
    check("rd_hold",    64'(ba_rd),   64'h1);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("rd_drop_on_ack", 64'(ba_rd), 64'h0);
    tick();
    check("rd_no_early_ok", 64'(ch_ok), 64'h0);
    sdram_dout = 16'hBEEF; man_rdy = 1'b1;
    tick();
    check("rd_ok",      64'(ch_ok),   64'h4);
    check("rd_dout",    64'(ch_dout), 64'hBEEF);
    check("rd_busy_done", 64'(busy),  64'h0);
    man_rdy = 1'b0; ch_rd = '0; sdram_dout = '0;
    tick();
    check("rd_ok_one_cycle", 64'(ch_ok), 64'h0);

    // ---------------- masked write on channel 1, ack+rdy together ----------------
    ch_din[1*DW +: DW] = 16'hA55A;
    ch_din_m[1*2 +: 2] = 2'b10;
    ch_wr = 4'b0010;
    tick();
    check("wr_ba_wr",   64'(ba_wr),    64'h1);
    check("wr_ba_rd",   64'(ba_rd),    64'h0);
    check("wr_ba_din",  64'(ba_din),   64'hA55A);
    check("wr_ba_din_m", 64'(ba_din_m), 64'h2);
    man_ack = 1'b1; man_rdy = 1'b1; sdram_dout = 16'h1111;
    tick();
    check("wr_ok",      64'(ch_ok),    64'h2);
    check("wr_dout_kept", 64'(ch_dout), 64'hBEEF);
    check("wr_ba_wr_drop", 64'(ba_wr), 64'h0);
    man_ack = 1'b0; man_rdy = 1'b0; ch_wr = '0; sdram_dout = '0;
    tick();

    // ---------------- rd and wr both set: treated as a write ----------------
    ch_rd = 4'b1000; ch_wr = 4'b1000;
    tick();
    check("rdwr_is_wr", 64'({ba_rd, ba_wr}), 64'h1);
    man_ack = 1'b1; man_rdy = 1'b1;
    tick();
    check("rdwr_ok",    64'(ch_ok),    64'h8);
    man_ack = 1'b0; man_rdy = 1'b0; ch_rd = '0; ch_wr = '0;
    tick();

    // ---------------- round-robin fairness from reset ----------------
    do_reset();
    auto_rsp = 1'b1;
    ch_rd = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_ok(1'b0, ok);
      check($sformatf("rr_grant%0d", n), 64'(ok), 64'(4'b0001 << ((n + 1) % CH)));
    end
    ch_rd = '0;
    repeat (8) tick();
    check("rr_idle", 64'(busy), 64'h0);
    auto_rsp = 1'b0;

    // ---------------- download block and async reset in WAIT ----------------
    do_reset();
    ch_addr[0*AW +: AW] = 22'h00100;
    ch_addr[1*AW +: AW] = 22'h00200;
    ch_rd = 4'b0001;
    tick();
    downloading = 1'b1; man_ack = 1'b1;
    tick();
    man_ack = 1'b0; man_rdy = 1'b1; sdram_dout = 16'h1234;
    ch_rd = 4'b0011;
    tick();
    check("dl_inflight_ok",   64'(ch_ok),   64'h1);
    check("dl_inflight_dout", 64'(ch_dout), 64'h1234);
    man_rdy = 1'b0; ch_rd = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dl_blocked%0d", i), 64'({ba_rd, busy}), 64'h0);
    end
    downloading = 1'b0;
    tick();
    check("dl_release_rd",   64'(ba_rd),   64'h1);
    check("dl_release_addr", 64'(ba_addr), 64'h200);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("ar_in_wait_busy", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",    64'(busy),    64'h0);
    check("ar_ba_rd",   64'(ba_rd),   64'h0);
    check("ar_ch_ok",   64'(ch_ok),   64'h0);
    check("ar_ba_addr", 64'(ba_addr), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_reissue_rd",   64'(ba_rd),   64'h1);
    check("ar_reissue_addr", 64'(ba_addr), 64'h200);
    man_ack = 1'b1; man_rdy = 1'b1;
    tick();
    check("ar_reissue_ok", 64'(ch_ok), 64'h2);
    man_ack = 1'b0; man_rdy = 1'b0; ch_rd = '0;
    tick();

    // ---------------- fixed priority ----------------
    fp_rd = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      wait_ok(1'b1, ok);
      check($sformatf("fp_ch0_%0d", n), 64'(ok), 64'h1);
    end
    fp_rd = 4'b1000;
    wait_ok(1'b1, ok);
    check("fp_ch3_after_drop", 64'(ok), 64'h8);
    fp_rd = '0;
    repeat (6) tick();
    check("fp_idle", 64'(fp_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
